// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage and the data memory.
// The memory stage is the master: it issues the request and holds it
// steady until the memory answers with a one-cycle ack.
interface mem_stage_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: turns execute-stage load/store requests into a
// single held data-memory transaction, formats load data, and produces
// the writeback for both memory and non-memory instructions.
// A request is accepted only when exactly one enable is set and op_spec
// names an operation in the matching direction (loads with read, stores
// with write); anything else carrying an enable is ignored, except that
// both enables together or a misaligned access raise a misalign pulse.
module mem_stage #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  op_type,
  input  logic [4:0]  op_spec,
  input  logic [4:0]  rd_ind,
  input  logic [31:0] rd_dat,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dat,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  output logic        stall,
  mem_stage_if.master dm,
  output logic        wb_valid,
  output logic [4:0]  wb_rd_ind,
  output logic [31:0] wb_dat,
  output logic        misalign,
  output logic        bus_err
);

  localparam logic [4:0] OP_LB  = 5'd0;
  localparam logic [4:0] OP_LH  = 5'd1;
  localparam logic [4:0] OP_LW  = 5'd2;
  localparam logic [4:0] OP_LBU = 5'd3;
  localparam logic [4:0] OP_LHU = 5'd4;
  localparam logic [4:0] OP_SB  = 5'd5;
  localparam logic [4:0] OP_SH  = 5'd6;
  localparam logic [4:0] OP_SW  = 5'd7;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t state;
  state_t state_nxt;

  logic             is_load;
  logic             is_store;
  logic             is_byte;
  logic             is_half;
  logic             is_word;
  logic             aligned;
  logic             req_valid;
  logic             req_ok;
  logic             req_bad;
  logic [3:0]       be_c;
  logic [31:0]      wdata_c;

  logic [CNT_W-1:0] cnt;
  logic             we_r;
  logic [31:0]      addr_r;
  logic [31:0]      wdata_r;
  logic [3:0]       be_r;
  logic [4:0]       spec_r;
  logic [1:0]       lane_r;
  logic [4:0]       rd_r;
  logic             timed_out;

  // Load-lane extraction: pick the byte/halfword addressed by the low
  // address bits, then sign- or zero-extend according to the load kind.
  function automatic logic [31:0] format_load(input logic [4:0]  spec,
                                              input logic [1:0]  lane,
                                              input logic [31:0] data);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = data[7:0];
      2'd1:    b = data[15:8];
      2'd2:    b = data[23:16];
      default: b = data[31:24];
    endcase
    h = lane[1] ? data[31:16] : data[15:0];
    case (spec)
      OP_LB:   format_load = {{24{b[7]}}, b};
      OP_LBU:  format_load = {24'h000000, b};
      OP_LH:   format_load = {{16{h[15]}}, h};
      OP_LHU:  format_load = {16'h0000, h};
      default: format_load = data;
    endcase
  endfunction

  // Decode the incoming request: operation kind, size, alignment and the
  // byte-enable / write-data pattern that would go onto the bus.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    is_byte  = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    case (op_spec)
      OP_LB, OP_LBU: begin is_load  = 1'b1; is_byte = 1'b1; end
      OP_LH, OP_LHU: begin is_load  = 1'b1; is_half = 1'b1; end
      OP_LW:         begin is_load  = 1'b1; is_word = 1'b1; end
      OP_SB:         begin is_store = 1'b1; is_byte = 1'b1; end
      OP_SH:         begin is_store = 1'b1; is_half = 1'b1; end
      OP_SW:         begin is_store = 1'b1; is_word = 1'b1; end
      default:       ;
    endcase

    if (is_word)      aligned = (mem_addr[1:0] == 2'b00);
    else if (is_half) aligned = ~mem_addr[0];
    else              aligned = 1'b1;

    req_valid = (mem_read_en ^ mem_write_en) &
                ((mem_read_en & is_load) | (mem_write_en & is_store));
    req_ok    = req_valid & aligned;
    req_bad   = (mem_read_en & mem_write_en) | (req_valid & ~aligned);

    if (is_byte) begin
      be_c    = 4'b0001 << mem_addr[1:0];
      wdata_c = {4{mem_dat[7:0]}};
    end else if (is_half) begin
      be_c    = mem_addr[1] ? 4'b1100 : 4'b0011;
      wdata_c = {2{mem_dat[15:0]}};
    end else begin
      be_c    = 4'b1111;
      wdata_c = mem_dat;
    end
  end

  assign timed_out = (cnt == CNT_LAST);

  // State register; reset drops any transaction in flight immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic plus the handshake outputs derived from the state.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        stall = req_ok & ~rst;
        if (req_ok) state_nxt = ACCESS;
      end
      ACCESS: begin
        stall = ~rst;
        if (dm.dm_ack || timed_out) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign dm.dm_req   = (state == ACCESS);
  assign dm.dm_we    = we_r;
  assign dm.dm_addr  = addr_r;
  assign dm.dm_wdata = wdata_r;
  assign dm.dm_be    = be_r;

  // Request capture, access timer, load formatting and writeback/fault pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      we_r      <= 1'b0;
      addr_r    <= 32'h0;
      wdata_r   <= 32'h0;
      be_r      <= 4'h0;
      spec_r    <= 5'h0;
      lane_r    <= 2'h0;
      rd_r      <= 5'h0;
      wb_valid  <= 1'b0;
      wb_rd_ind <= 5'h0;
      wb_dat    <= 32'h0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req_ok) begin
            we_r    <= is_store;
            addr_r  <= {mem_addr[31:2], 2'b00};
            wdata_r <= wdata_c;
            be_r    <= be_c;
            spec_r  <= op_spec;
            lane_r  <= mem_addr[1:0];
            rd_r    <= rd_ind;
          end else if (req_bad) begin
            misalign <= 1'b1;
          end else if (!mem_read_en && !mem_write_en) begin
            wb_valid  <= (rd_ind != 5'd0) &&
                         ((op_type == 4'd0) || (op_type == 4'd3) || (op_type == 4'd4));
            wb_rd_ind <= rd_ind;
            wb_dat    <= rd_dat;
          end
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          if (dm.dm_ack) begin
            if (!we_r) begin
              wb_valid  <= (rd_r != 5'd0);
              wb_rd_ind <= rd_r;
              wb_dat    <= format_load(spec_r, lane_r, dm.dm_rdata);
            end
          end else if (timed_out) begin
            bus_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: a table of single-transaction vectors
// followed by hand-written timeout and reset-abort sequences.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  op_type;
  logic [4:0]  op_spec;
  logic [4:0]  rd_ind;
  logic [31:0] rd_dat;
  logic [31:0] mem_addr;
  logic [31:0] mem_dat;
  logic        mem_read_en;
  logic        mem_write_en;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd_ind;
  logic [31:0] wb_dat;
  logic        misalign;
  logic        bus_err;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_stage_if dm_bus ();

  mem_stage #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .op_type      (op_type),
    .op_spec      (op_spec),
    .rd_ind       (rd_ind),
    .rd_dat       (rd_dat),
    .mem_addr     (mem_addr),
    .mem_dat      (mem_dat),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .stall        (stall),
    .dm           (dm_bus.master),
    .wb_valid     (wb_valid),
    .wb_rd_ind    (wb_rd_ind),
    .wb_dat       (wb_dat),
    .misalign     (misalign),
    .bus_err      (bus_err)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op_type;
    logic [4:0]  op_spec;
    logic [4:0]  rd;
    logic [31:0] rd_dat;
    logic [31:0] addr;
    logic [31:0] dat;
    logic        ren;
    logic        wen;
    int          ack_delay;
    logic [31:0] rdata;
    logic        exp_access;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic        exp_wb_valid;
    logic [31:0] exp_wb_dat;
    logic        exp_misalign;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic addMem(input string name, input logic [4:0] spec, input logic [4:0] rd,
                        input logic [31:0] addr, input logic [31:0] dat,
                        input logic ren, input logic wen, input int delay, input logic [31:0] rdata,
                        input logic acc, input logic we, input logic [3:0] be,
                        input logic [31:0] daddr, input logic [31:0] wdata,
                        input logic wbv, input logic [31:0] wbdat, input logic mis);
    vec_t v;
    v.name = name; v.op_type = 4'd1; v.op_spec = spec; v.rd = rd; v.rd_dat = 32'h0;
    v.addr = addr; v.dat = dat; v.ren = ren; v.wen = wen; v.ack_delay = delay; v.rdata = rdata;
    v.exp_access = acc; v.exp_we = we; v.exp_be = be; v.exp_addr = daddr; v.exp_wdata = wdata;
    v.exp_wb_valid = wbv; v.exp_wb_dat = wbdat; v.exp_misalign = mis;
    vecs.push_back(v);
  endtask

  task automatic addAlu(input string name, input logic [3:0] opt, input logic [4:0] rd,
                        input logic [31:0] rdd, input logic wbv);
    vec_t v;
    v.name = name; v.op_type = opt; v.op_spec = 5'd0; v.rd = rd; v.rd_dat = rdd;
    v.addr = 32'h0; v.dat = 32'h0; v.ren = 1'b0; v.wen = 1'b0; v.ack_delay = 0; v.rdata = 32'h0;
    v.exp_access = 1'b0; v.exp_we = 1'b0; v.exp_be = 4'h0; v.exp_addr = 32'h0; v.exp_wdata = 32'h0;
    v.exp_wb_valid = wbv; v.exp_wb_dat = rdd; v.exp_misalign = 1'b0;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    op_type      = v.op_type;
    op_spec      = v.op_spec;
    rd_ind       = v.rd;
    rd_dat       = v.rd_dat;
    mem_addr     = v.addr;
    mem_dat      = v.dat;
    mem_read_en  = v.ren;
    mem_write_en = v.wen;
  endtask

  task automatic bubble();
    op_type      = 4'd1;
    op_spec      = 5'd0;
    rd_ind       = 5'd0;
    rd_dat       = 32'h0;
    mem_addr     = 32'h0;
    mem_dat      = 32'h0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Hard stop in case something upstream of the checks deadlocks.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence.
  initial begin
    vec_t v;
    rst = 1'b1;
    bubble();
    dm_bus.dm_ack   = 1'b0;
    dm_bus.dm_rdata = 32'h0;

    addMem("sw_100",   5'd7, 5'd0,  32'h100, 32'hDEADBEEF, 1'b0, 1'b1, 3, 32'h0,
           1'b1, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    addMem("lb_203",   5'd0, 5'd5,  32'h203, 32'h0, 1'b1, 1'b0, 1, 32'h80FFFFFF,
           1'b1, 1'b0, 4'h8, 32'h200, 32'h0, 1'b1, 32'hFFFFFF80, 1'b0);
    addMem("lbu_203",  5'd3, 5'd5,  32'h203, 32'h0, 1'b1, 1'b0, 1, 32'h80FFFFFF,
           1'b1, 1'b0, 4'h8, 32'h200, 32'h0, 1'b1, 32'h00000080, 1'b0);
    addMem("sh_102",   5'd6, 5'd0,  32'h102, 32'h1234ABCD, 1'b0, 1'b1, 2, 32'h0,
           1'b1, 1'b1, 4'hC, 32'h100, 32'hABCDABCD, 1'b0, 32'h0, 1'b0);
    addMem("lw_mis",   5'd2, 5'd4,  32'h102, 32'h0, 1'b1, 1'b0, 1, 32'h0,
           1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    addMem("lh_302",   5'd1, 5'd3,  32'h302, 32'h0, 1'b1, 1'b0, 2, 32'h80011234,
           1'b1, 1'b0, 4'hC, 32'h300, 32'h0, 1'b1, 32'hFFFF8001, 1'b0);
    addMem("lhu_300",  5'd4, 5'd3,  32'h300, 32'h0, 1'b1, 1'b0, 1, 32'h1234F00D,
           1'b1, 1'b0, 4'h3, 32'h300, 32'h0, 1'b1, 32'h0000F00D, 1'b0);
    addMem("lw_404",   5'd2, 5'd31, 32'h404, 32'h0, 1'b1, 1'b0, 1, 32'hCAFEBABE,
           1'b1, 1'b0, 4'hF, 32'h404, 32'h0, 1'b1, 32'hCAFEBABE, 1'b0);
    addMem("sb_101",   5'd5, 5'd0,  32'h101, 32'h000000A5, 1'b0, 1'b1, 1, 32'h0,
           1'b1, 1'b1, 4'h2, 32'h100, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b0);
    addMem("lw_rd0",   5'd2, 5'd0,  32'h008, 32'h0, 1'b1, 1'b0, 1, 32'h12345678,
           1'b1, 1'b0, 4'hF, 32'h008, 32'h0, 1'b0, 32'h0, 1'b0);
    addMem("lh_mis",   5'd1, 5'd2,  32'h201, 32'h0, 1'b1, 1'b0, 1, 32'h0,
           1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    addMem("both_en",  5'd0, 5'd2,  32'h000, 32'h0, 1'b1, 1'b1, 1, 32'h0,
           1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    addMem("bad_spec", 5'd9, 5'd2,  32'h000, 32'h0, 1'b1, 1'b0, 1, 32'h0,
           1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    addAlu("alu_t0",  4'd0, 5'd9,  32'h11112222, 1'b1);
    addAlu("alu_t3",  4'd3, 5'd10, 32'h33334444, 1'b1);
    addAlu("alu_t4",  4'd4, 5'd12, 32'h55556666, 1'b1);
    addAlu("alu_t2",  4'd2, 5'd11, 32'h77778888, 1'b0);
    addAlu("alu_rd0", 4'd0, 5'd0,  32'h9999AAAA, 1'b0);

    #12;
    checkOutput("rst/stall",    stall,          0);
    checkOutput("rst/dm_req",   dm_bus.dm_req,  0);
    checkOutput("rst/dm_be",    dm_bus.dm_be,   0);
    checkOutput("rst/dm_addr",  dm_bus.dm_addr, 0);
    checkOutput("rst/wb_valid", wb_valid,       0);
    checkOutput("rst/wb_dat",   wb_dat,         0);
    checkOutput("rst/misalign", misalign,       0);
    checkOutput("rst/bus_err",  bus_err,        0);
    nextCycle();
    rst = 1'b0;
    nextCycle();

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      applyStimulus(v);
      @(negedge clk);
      checkOutput({v.name, "/stall_req"}, stall, v.exp_access);
      checkOutput({v.name, "/req_idle"}, dm_bus.dm_req, 0);
      nextCycle();
      if (v.exp_access) begin
        for (int k = 1; k <= v.ack_delay; k++) begin
          dm_bus.dm_ack   = (k == v.ack_delay);
          dm_bus.dm_rdata = (k == v.ack_delay) ? v.rdata : 32'hBAD0BAD0;
          @(negedge clk);
          checkOutput({v.name, "/dm_req"},  dm_bus.dm_req,  1);
          checkOutput({v.name, "/dm_we"},   dm_bus.dm_we,   v.exp_we);
          checkOutput({v.name, "/dm_be"},   dm_bus.dm_be,   v.exp_be);
          checkOutput({v.name, "/dm_addr"}, dm_bus.dm_addr, v.exp_addr);
          if (v.exp_we) checkOutput({v.name, "/dm_wdata"}, dm_bus.dm_wdata, v.exp_wdata);
          checkOutput({v.name, "/stall_acc"}, stall, 1);
          nextCycle();
        end
        dm_bus.dm_ack   = 1'b0;
        dm_bus.dm_rdata = 32'h0;
        @(negedge clk);
        checkOutput({v.name, "/wb_valid"},  wb_valid,      v.exp_wb_valid);
        if (v.exp_wb_valid) begin
          checkOutput({v.name, "/wb_dat"},    wb_dat,    v.exp_wb_dat);
          checkOutput({v.name, "/wb_rd_ind"}, wb_rd_ind, v.rd);
        end
        checkOutput({v.name, "/stall_done"}, stall,         0);
        checkOutput({v.name, "/req_done"},   dm_bus.dm_req, 0);
        checkOutput({v.name, "/bus_err"},    bus_err,       0);
        nextCycle();
        bubble();
      end else begin
        bubble();
        @(negedge clk);
        checkOutput({v.name, "/misalign"}, misalign,      v.exp_misalign);
        checkOutput({v.name, "/wb_valid"}, wb_valid,      v.exp_wb_valid);
        checkOutput({v.name, "/no_req"},   dm_bus.dm_req, 0);
        if (v.exp_wb_valid) begin
          checkOutput({v.name, "/wb_dat"},    wb_dat,    v.exp_wb_dat);
          checkOutput({v.name, "/wb_rd_ind"}, wb_rd_ind, v.rd);
        end
        nextCycle();
      end
      @(negedge clk);
      checkOutput({v.name, "/mis_pulse"}, misalign, 0);
      checkOutput({v.name, "/wbv_pulse"}, wb_valid, 0);
      nextCycle();
    end

    // Timeout: lw with no ack holds dm_req for four cycles, then aborts.
    op_spec = 5'd2; rd_ind = 5'd6; mem_addr = 32'h40; mem_read_en = 1'b1;
    @(negedge clk);
    checkOutput("to/stall_req", stall, 1);
    nextCycle();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("to/dm_req_%0d", k),  dm_bus.dm_req, 1);
      checkOutput($sformatf("to/bus_err_%0d", k), bus_err,       0);
      nextCycle();
    end
    dm_bus.dm_ack = 1'b1; dm_bus.dm_rdata = 32'h5A5A5A5A;
    @(negedge clk);
    checkOutput("to/bus_err",  bus_err,       1);
    checkOutput("to/wb_valid", wb_valid,      0);
    checkOutput("to/stall",    stall,         0);
    checkOutput("to/dm_req",   dm_bus.dm_req, 0);
    nextCycle();
    bubble();
    @(negedge clk);
    checkOutput("to/bus_err_pulse", bus_err,       0);
    checkOutput("to/late_wbv",      wb_valid,      0);
    checkOutput("to/late_req",      dm_bus.dm_req, 0);
    nextCycle();
    dm_bus.dm_ack = 1'b0;
    @(negedge clk);
    checkOutput("to/idle_wbv", wb_valid,      0);
    checkOutput("to/idle_req", dm_bus.dm_req, 0);
    nextCycle();

    // Reset in the middle of an access abandons it; a later ack is ignored.
    op_spec = 5'd2; rd_ind = 5'd7; mem_addr = 32'h50; mem_read_en = 1'b1;
    nextCycle();
    @(negedge clk);
    checkOutput("rs/dm_req_acc", dm_bus.dm_req, 1);
    nextCycle();
    rst = 1'b1;
    #1;
    checkOutput("rs/dm_req_rst", dm_bus.dm_req, 0);
    checkOutput("rs/stall_rst",  stall,         0);
    checkOutput("rs/wbv_rst",    wb_valid,      0);
    nextCycle();
    rst = 1'b0;
    bubble();
    dm_bus.dm_ack = 1'b1; dm_bus.dm_rdata = 32'h01020304;
    @(negedge clk);
    checkOutput("rs/dm_req_ack", dm_bus.dm_req, 0);
    checkOutput("rs/stall_ack",  stall,         0);
    nextCycle();
    dm_bus.dm_ack = 1'b0;
    @(negedge clk);
    checkOutput("rs/wbv_after", wb_valid, 0);
    checkOutput("rs/req_after", dm_bus.dm_req, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("rs/wbv_after2", wb_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
